// File: rtl/wb_sdram_ctrl_pkg.sv
// wb_sdram_ctrl_pkg: shared state encodings for the SDRAM controller read path
package wb_sdram_ctrl_pkg;
   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_FILL = 2'd2;
endpackage

// File: rtl/rd_line_mem.sv
// rd_line_mem: line data storage, one write port and one asynchronous read port
module rd_line_mem #(
   parameter int DW    = 32,
   parameter int WORDS = 8
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(WORDS)-1:0] wadr,
   input  logic [DW-1:0]            wdat,
   input  logic [$clog2(WORDS)-1:0] radr,
   output logic [DW-1:0]            rdat
);
   logic [DW-1:0] mem [WORDS];
   always_ff @(posedge clk)
      if (we) mem[wadr] <= wdat;
   assign rdat = mem[radr];
endmodule

// File: rtl/wb_rd_buffer.sv
// wb_rd_buffer: single-line Wishbone read buffer refilled from the SDRAM read upsizer
module wb_rd_buffer #(
   parameter int WB_DW     = 32,
   parameter int AW        = 24,
   parameter int BUF_WORDS = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [AW-1:0]    wb_adr_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   output logic [WB_DW-1:0] wb_dat_o,
   output logic             wb_ack_o,
   output logic             req_valid_o,
   output logic [AW-1:0]    req_adr_o,
   input  logic             req_ready_i,
   input  logic [AW-3:0]    s_adr_i,
   input  logic [WB_DW-1:0] s_data_i,
   input  logic             s_valid_i,
   output logic             s_ready_o,
   input  logic             inval_i,
   input  logic [AW-1:0]    inval_adr_i
);
   import wb_sdram_ctrl_pkg::*;
   localparam int LW = $clog2(BUF_WORDS);
   localparam int TW = AW - 2 - LW;
   logic [1:0]           state;
   logic [TW-1:0]        tag;
   logic [BUF_WORDS-1:0] valid;
   logic                 stale;
   logic [LW:0]          cnt;
   logic                 rd, tag_hit, inval_hit, beat_ok, keep, fwd, hit, miss, unused;
   logic [LW-1:0]        idx, beat_idx;
   logic [WB_DW-1:0]     mem_dat;
   assign rd        = wb_cyc_i & wb_stb_i & ~wb_we_i;
   assign idx       = wb_adr_i[1+LW:2];
   assign beat_idx  = s_adr_i[LW-1:0];
   assign tag_hit   = wb_adr_i[AW-1:2+LW] == tag;
   assign inval_hit = inval_i && inval_adr_i[AW-1:2+LW] == tag;
   assign beat_ok   = state == ST_FILL && s_valid_i && s_adr_i[AW-3:LW] == tag;
   assign keep      = beat_ok & ~stale & ~inval_hit;
   // A beat landing on the requested word is forwarded so the ack follows that beat directly
   assign fwd       = keep && beat_idx == idx;
   assign hit       = rd & tag_hit & ~stale & ~inval_hit & (valid[idx] | fwd);
   assign miss      = rd & ~hit & ~wb_ack_o;
   assign req_adr_o = {tag, {(LW+2){1'b0}}};
   assign s_ready_o = 1'b1;
   assign unused    = &{1'b0, wb_adr_i[1:0], inval_adr_i[1+LW:0]};
   rd_line_mem #(.DW(WB_DW), .WORDS(BUF_WORDS)) u_mem (
      .clk(clk), .we(beat_ok), .wadr(beat_idx), .wdat(s_data_i), .radr(idx), .rdat(mem_dat)
   );
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_IDLE;
         tag         <= '0;
         valid       <= '0;
         stale       <= 1'b0;
         cnt         <= '0;
         req_valid_o <= 1'b0;
         wb_ack_o    <= 1'b0;
         wb_dat_o    <= '0;
      end else begin
         wb_ack_o <= hit & ~wb_ack_o;
         if (hit & ~wb_ack_o) wb_dat_o <= fwd ? s_data_i : mem_dat;
         if (state == ST_IDLE && miss) begin
            tag         <= wb_adr_i[AW-1:2+LW];
            valid       <= '0;
            stale       <= 1'b0;
            req_valid_o <= 1'b1;
            state       <= ST_REQ;
         end else if (state == ST_REQ && req_ready_i) begin
            req_valid_o <= 1'b0;
            cnt         <= '0;
            state       <= ST_FILL;
         end else if (beat_ok) begin
            cnt <= cnt + 1'b1;
            if (keep) valid[beat_idx] <= 1'b1;
            if (cnt == (LW+1)'(BUF_WORDS-1)) state <= ST_IDLE;
         end
         // Invalidate is applied last so it overrides any bit set by a concurrent beat
         if (inval_hit) begin
            valid <= '0;
            if (state != ST_IDLE) stale <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_wb_rd_buffer.sv
// tb_wb_rd_buffer: randomized self-checking bench against an SDRAM content model
module tb_wb_rd_buffer;
   logic        clk = 0, rst = 1;
   logic [23:0] wb_adr_i = '0, req_adr_o, inval_adr_i = '0;
   logic        wb_cyc_i = 0, wb_stb_i = 0, wb_we_i = 0, wb_ack_o, req_valid_o, req_ready_i = 0;
   logic [31:0] wb_dat_o, s_data_i = '0;
   logic [21:0] s_adr_i = '0;
   logic        s_valid_i = 0, s_ready_o, inval_i = 0;
   int          checks = 0, errors = 0, acks = 0;
   logic [31:0] ack_dat = '0;
   logic [31:0] seed;
   logic [21:0] cur = '0;

   wb_rd_buffer dut (
      .clk(clk), .rst(rst), .wb_adr_i(wb_adr_i), .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i),
      .wb_we_i(wb_we_i), .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .req_valid_o(req_valid_o),
      .req_adr_o(req_adr_o), .req_ready_i(req_ready_i), .s_adr_i(s_adr_i), .s_data_i(s_data_i),
      .s_valid_i(s_valid_i), .s_ready_o(s_ready_o), .inval_i(inval_i), .inval_adr_i(inval_adr_i)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1, "watchdog");
   end

   // SDRAM content: every word address has a fixed pseudo-random value
   function automatic logic [31:0] mem_word(input logic [21:0] w);
      return (32'(w) * 32'h9E3779B1) ^ seed;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_read(input logic [23:0] a);
      wb_adr_i = a;
      wb_cyc_i = 1;
      wb_stb_i = 1;
      wb_we_i  = 0;
   endtask

   task automatic end_read();
      wb_cyc_i = 0;
      wb_stb_i = 0;
   endtask

   task automatic do_reset();
      end_read();
      rst = 1;
      tick();
      rst = 0;
   endtask

   task automatic beat(input logic [21:0] w, input logic inv, input logic [23:0] inv_adr);
      s_valid_i   = 1;
      s_adr_i     = w;
      s_data_i    = mem_word(w);
      inval_i     = inv;
      inval_adr_i = inv_adr;
      tick();
      s_valid_i = 0;
      inval_i   = 0;
      if (wb_ack_o) begin
         acks++;
         ack_dat = wb_dat_o;
         end_read();
      end
   endtask

   task automatic fill(input logic [21:0] base, input bit shuf);
      int ord[8];
      for (int i = 0; i < 8; i++) ord[i] = i;
      if (shuf)
         for (int i = 7; i > 0; i--) begin
            int j = $urandom_range(0, i);
            int t = ord[i];
            ord[i] = ord[j];
            ord[j] = t;
         end
      for (int i = 0; i < 8; i++) beat(base | 22'(ord[i]), 0, '0);
   endtask

   task automatic wait_req(output bit ok);
      ok = 0;
      for (int i = 0; i < 20; i++) begin
         if (req_valid_o) begin
            ok = 1;
            return;
         end
         tick();
      end
   endtask

   task automatic grant();
      req_ready_i = 1;
      tick();
      req_ready_i = 0;
   endtask

   task automatic test_reset();
      rst = 1;
      tick();
      tick();
      rst = 0;
      start_read(24'h000100);
      tick();
      rst = 1;
      tick();
      rst = 0;
      end_read();
      checks++;
      if (req_valid_o !== 0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", req_valid_o); end
      checks++;
      if (wb_ack_o !== 0) begin errors++; $display("FAIL reset_ack: got %b expected 0", wb_ack_o); end
      checks++;
      if (wb_dat_o !== 0) begin errors++; $display("FAIL reset_dat: got %h expected 0", wb_dat_o); end
      checks++;
      if (s_ready_o !== 1) begin errors++; $display("FAIL s_ready: got %b expected 1", s_ready_o); end
      tick();
      checks++;
      if (req_valid_o !== 0) begin errors++; $display("FAIL reset_idle_req: got %b expected 0", req_valid_o); end
   endtask

   task automatic test_cold_read();
      bit ok;
      int d;
      acks = 0;
      start_read(24'h000100);
      tick();
      wait_req(ok);
      checks++;
      if (!ok || req_adr_o !== 24'h000100) begin
         errors++; $display("FAIL cold_req: got valid=%b adr=%h expected 1/000100", ok, req_adr_o);
      end
      d = $urandom_range(0, 3);
      for (int i = 0; i < d; i++) begin
         tick();
         checks++;
         if (req_valid_o !== 1 || req_adr_o !== 24'h000100) begin
            errors++; $display("FAIL req_hold: got valid=%b adr=%h expected 1/000100", req_valid_o, req_adr_o);
         end
      end
      grant();
      checks++;
      if (req_valid_o !== 0) begin errors++; $display("FAIL req_drop: got %b expected 0", req_valid_o); end
      fill(22'h40, 0);
      checks++;
      if (acks !== 1 || ack_dat !== mem_word(22'h40)) begin
         errors++; $display("FAIL cold_ack: got acks=%0d dat=%h expected 1/%h", acks, ack_dat, mem_word(22'h40));
      end
      tick();
      checks++;
      if (req_valid_o !== 0) begin errors++; $display("FAIL cold_no_req: got %b expected 0", req_valid_o); end
      cur = 22'h40;
   endtask

   task automatic test_hit_after_fill();
      start_read(24'h00011C);
      tick();
      checks++;
      if (wb_ack_o !== 1 || wb_dat_o !== mem_word(22'h47) || req_valid_o !== 0) begin
         errors++; $display("FAIL hit_1c: got ack=%b dat=%h req=%b expected 1/%h/0", wb_ack_o, wb_dat_o, req_valid_o, mem_word(22'h47));
      end
      tick();
      checks++;
      if (wb_ack_o !== 0) begin errors++; $display("FAIL ack_gap: got %b expected 0", wb_ack_o); end
      end_read();
      tick();
      for (int i = 0; i < 6; i++) begin
         int k = $urandom_range(0, 7);
         start_read(24'h000100 + 24'(4 * k) + 24'($urandom_range(0, 3)));
         tick();
         checks++;
         if (wb_ack_o !== 1 || wb_dat_o !== mem_word(22'h40 + 22'(k))) begin
            errors++; $display("FAIL hit_word%0d: got ack=%b dat=%h expected 1/%h", k, wb_ack_o, wb_dat_o, mem_word(22'h40 + 22'(k)));
         end
         end_read();
         tick();
      end
   endtask

   task automatic test_random_lines();
      for (int r = 0; r < 5; r++) begin
         logic [21:0] base;
         int k, d;
         bit ok;
         base = 22'($urandom) & 22'h3FFFF8;
         if (base == cur) base = base ^ 22'h8;
         k = $urandom_range(0, 7);
         acks = 0;
         start_read({base, 2'b00} + 24'(4 * k));
         tick();
         wait_req(ok);
         checks++;
         if (!ok || req_adr_o !== {base, 2'b00}) begin
            errors++; $display("FAIL rand_req: got valid=%b adr=%h expected 1/%h", ok, req_adr_o, {base, 2'b00});
         end
         d = $urandom_range(0, 3);
         for (int i = 0; i < d; i++) tick();
         grant();
         fill(base, 1);
         tick();
         checks++;
         if (acks !== 1 || ack_dat !== mem_word(base + 22'(k))) begin
            errors++; $display("FAIL rand_ack: got acks=%0d dat=%h expected 1/%h", acks, ack_dat, mem_word(base + 22'(k)));
         end
         cur = base;
      end
   endtask

   task automatic test_drop_beat();
      bit ok;
      do_reset();
      acks = 0;
      start_read(24'h000100);
      tick();
      wait_req(ok);
      checks++;
      if (!ok) begin errors++; $display("FAIL drop_req: got 0 expected 1"); end
      grant();
      for (int i = 0; i < 3; i++) beat(22'h40 + 22'(i), 0, '0);
      beat(22'h99, 0, '0);
      for (int i = 3; i < 7; i++) beat(22'h40 + 22'(i), 0, '0);
      start_read(24'h002000);
      for (int i = 0; i < 3; i++) begin
         tick();
         checks++;
         if (req_valid_o !== 0) begin errors++; $display("FAIL drop_still_fill: got %b expected 0", req_valid_o); end
      end
      wb_adr_i = 24'h000104;
      beat(22'h47, 0, '0);
      checks++;
      if (acks !== 2 || ack_dat !== mem_word(22'h41)) begin
         errors++; $display("FAIL drop_data: got acks=%0d dat=%h expected 2/%h", acks, ack_dat, mem_word(22'h41));
      end
      tick();
      start_read(24'h002000);
      tick();
      wait_req(ok);
      checks++;
      if (!ok || req_adr_o !== 24'h002000) begin
         errors++; $display("FAIL drop_idle: got valid=%b adr=%h expected 1/002000", ok, req_adr_o);
      end
      grant();
      fill(22'h800, 1);
      end_read();
      tick();
   endtask

   task automatic test_inval();
      bit ok;
      do_reset();
      acks = 0;
      start_read(24'h000100);
      tick();
      wait_req(ok);
      grant();
      for (int i = 0; i < 3; i++) beat(22'h40 + 22'(i), 0, '0);
      beat(22'h43, 1, 24'h000104);
      for (int i = 4; i < 8; i++) beat(22'h40 + 22'(i), 0, '0);
      start_read(24'h000108);
      tick();
      checks++;
      if (wb_ack_o !== 0) begin errors++; $display("FAIL stale_ack: got %b expected 0", wb_ack_o); end
      wait_req(ok);
      checks++;
      if (!ok || req_adr_o !== 24'h000100) begin
         errors++; $display("FAIL stale_req: got valid=%b adr=%h expected 1/000100", ok, req_adr_o);
      end
      grant();
      acks = 0;
      fill(22'h40, 1);
      checks++;
      if (acks !== 1 || ack_dat !== mem_word(22'h42)) begin
         errors++; $display("FAIL refill_ack: got acks=%0d dat=%h expected 1/%h", acks, ack_dat, mem_word(22'h42));
      end
      tick();
      start_read(24'h00011C);
      inval_i = 1;
      inval_adr_i = 24'h000400;
      tick();
      inval_i = 0;
      checks++;
      if (wb_ack_o !== 1 || wb_dat_o !== mem_word(22'h47)) begin
         errors++; $display("FAIL foreign_inval: got ack=%b dat=%h expected 1/%h", wb_ack_o, wb_dat_o, mem_word(22'h47));
      end
      end_read();
      tick();
      start_read(24'h000110);
      inval_i = 1;
      inval_adr_i = 24'h000110;
      tick();
      inval_i = 0;
      checks++;
      if (wb_ack_o !== 0) begin errors++; $display("FAIL rd_inval_ack: got %b expected 0", wb_ack_o); end
      wait_req(ok);
      checks++;
      if (!ok || req_adr_o !== 24'h000100) begin
         errors++; $display("FAIL rd_inval_req: got valid=%b adr=%h expected 1/000100", ok, req_adr_o);
      end
      grant();
      acks = 0;
      fill(22'h40, 1);
      checks++;
      if (acks !== 1 || ack_dat !== mem_word(22'h44)) begin
         errors++; $display("FAIL rd_inval_fill: got acks=%0d dat=%h expected 1/%h", acks, ack_dat, mem_word(22'h44));
      end
      end_read();
      tick();
   endtask

   task automatic test_reset_mid_fill();
      bit ok;
      do_reset();
      acks = 0;
      start_read(24'h000100);
      tick();
      wait_req(ok);
      grant();
      for (int i = 0; i < 3; i++) beat(22'h40 + 22'(i), 0, '0);
      start_read(24'h000104);
      rst = 1;
      tick();
      rst = 0;
      checks++;
      if (req_valid_o !== 0 || wb_ack_o !== 0 || wb_dat_o !== 0) begin
         errors++; $display("FAIL mid_reset: got req=%b ack=%b dat=%h expected 0/0/0", req_valid_o, wb_ack_o, wb_dat_o);
      end
      end_read();
      for (int i = 3; i < 8; i++) beat(22'h40 + 22'(i), 0, '0);
      checks++;
      if (acks !== 1) begin errors++; $display("FAIL mid_reset_acks: got %0d expected 1", acks); end
      start_read(24'h00010C);
      tick();
      checks++;
      if (wb_ack_o !== 0) begin errors++; $display("FAIL post_reset_ack: got %b expected 0", wb_ack_o); end
      wait_req(ok);
      checks++;
      if (!ok || req_adr_o !== 24'h000100) begin
         errors++; $display("FAIL post_reset_req: got valid=%b adr=%h expected 1/000100", ok, req_adr_o);
      end
      grant();
      fill(22'h40, 1);
      end_read();
      tick();
   endtask

   task automatic test_write();
      do_reset();
      wb_adr_i = 24'h000100;
      wb_we_i  = 1;
      wb_cyc_i = 1;
      wb_stb_i = 1;
      for (int i = 0; i < 20; i++) begin
         tick();
         checks++;
         if (wb_ack_o !== 0 || req_valid_o !== 0) begin
            errors++; $display("FAIL write_ignored: got ack=%b req=%b expected 0/0", wb_ack_o, req_valid_o);
         end
      end
      end_read();
      wb_we_i = 0;
   endtask

   initial begin
      seed = $urandom;
      test_reset();
      test_cold_read();
      test_hit_after_fill();
      test_random_lines();
      test_drop_beat();
      test_inval();
      test_reset_mid_fill();
      test_write();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
